spi_flash_arbiter: RTL
======================

# spi_flash_arbiter

Arbitrates two read requesters (port 0: instruction fetch; port 1: data/boot loader) onto the single `spi_flash_mem` word-read engine. It sequences each flash transaction, applies round-robin fairness and times out hung transfers. An optional single-entry word cache serves repeated reads without a flash access. It sits between the CPU bus decoder and `spi_flash_mem`.

## Interface
- `TIMEOUT_CYCLES`, 127: maximum cycles in WAIT before a transaction is aborted with error; must be > 70.
- `clk`  in  1  system clock
- `reset_n_i`  in  1  reset, asynchronous, active-low
- `req0_i` / `req1_i`  in  1  port read request; held high until that port's `valid` pulse
- `addr0_i` / `addr1_i`  in  22  word address; stable while `req` high
- `data0_o` / `data1_o`  out  32  read data; meaningful only with `valid`
- `valid0_o` / `valid1_o`  out  1  one-cycle completion pulse
- `err0_o` / `err1_o`  out  1  qualifies `valid`: transaction timed out, data = 0
- `flash_cs_o`, `flash_rd_o`  out  1  request strobes to flash engine
- `flash_addr_o`  out  22  latched word address
- `flash_data_i`  in  32  flash word
- `flash_ready_i`, `flash_valid_i`  in  1  engine idle / one-cycle data-valid

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any `req` high, pick winner via round-robin.
  - Both requesting: grant the port not served last.
  - `last_grant` resets to 1, so port 0 wins the first tie.
  - Cache hit (cache config only): go to RESP with cached data; no flash access.
  - Miss: requires `flash_ready_i`=1. Latch address and winner, then go to ISSUE. Otherwise stay in IDLE.
- ISSUE: `flash_cs_o`=`flash_rd_o`=1 for exactly this one cycle; `flash_addr_o` = latched address. Clear timeout counter; go to WAIT.
- WAIT:
  - On `flash_valid_i`: capture `flash_data_i`, update cache, go to RESP.
  - If counter reaches `TIMEOUT_CYCLES`: set error, data = 0, go to RESP. The cache is not updated on timeout.
- RESP: winner's `valid`=1 (plus `err` if set) for one cycle; update `last_grant`; go to IDLE.
  - If the winner dropped `req` before RESP, suppress `valid`/`err`. A completed flash fill still updates the cache.
- Address and winner are latched at grant. Later changes on `addr*_i` do not affect the transaction in flight.
- Only the granted port's outputs change. `data*_o` hold their last value between pulses.

## Timing
- Reset (async assert, sync deassert by surrounding logic):
  - state = IDLE, `last_grant` = 1, cache invalid.
  - All `valid*`, `err*`, `flash_cs_o`, `flash_rd_o` = 0.
  - `flash_addr_o` = 0; `data*_o` = 0.
- Reset mid-transaction aborts silently; no `valid` is emitted.
- Miss latency: `req` at cycle T with `flash_ready_i`=1 gives ISSUE at T+1. Then 64 flash cycles plus 1 capture cycle, and the `valid` pulse in RESP at T+67.
- Hit latency: `req` at T gives `valid` at T+1.
- Back-to-back: earliest next grant is the cycle after RESP, and only once `flash_ready_i`=1.
- Max service wait for a held request: one full transaction of the other port.

## Configuration
- `SPI_FLASH_ARB_CACHE_EN` defined:
  - Adds one entry: 22-bit tag, 32-bit data, valid bit.
  - Hits complete in 1 cycle and still alternate round-robin.
- Undefined: no cache storage; every request goes through ISSUE/WAIT.

## Structure
- Package `spi_flash_arb_pkg`:
  - state enum `arb_state_t` {IDLE, ISSUE, WAIT, RESP};
  - `FLASH_ADDR_W`=22, `FLASH_DATA_W`=32;
  - `FLASH_XFER_CYCLES`=64.
- Sub-module `spi_flash_rr_arb`: 2-input round-robin arbiter.
  - Inputs: `req[1:0]`, `last_grant`.
  - Outputs: one-hot `gnt[1:0]`.
  - Purely combinational.

## Test plan
- Single port 0 read, addr 0x000010, flash model returns 0xDEADBEEF → exactly one `flash_cs_o`/`flash_rd_o` cycle with `flash_addr_o`=0x000010; `valid0_o` pulse 67 cycles later with `data0_o`=0xDEADBEEF and `err0_o`=0.
- Both ports request at the same cycle (0x100, 0x200) → port 0 served first, then port 1; `flash_addr_o` sequence 0x100, 0x200; no `valid1_o` during port 0 transaction.
- Flash model never asserts valid → `valid1_o`=1, `err1_o`=1, `data1_o`=0 after `TIMEOUT_CYCLES` in WAIT; next request proceeds normally.
- With `SPI_FLASH_ARB_CACHE_EN`: port 0 reads 0x3FFFFF twice → second `valid0_o` one cycle after `req0_i`, no flash strobe. Without the macro → second read also strobes flash.
- `reset_n_i` pulsed low during WAIT → all outputs 0 immediately; no `valid` pulse; after release a new request completes correctly.
- Port 1 drops `req1_i` during WAIT → no `valid1_o`; cache (if enabled) holds the returned word; following port 0 request is granted normally.

Source files
------------

// File: rtl/spi_flash_arb_pkg.sv
// Shared types and constants for the SPI flash read arbiter.
//   arb_state_t       : transaction sequencer states
//   FLASH_ADDR_W      : flash word-address width
//   FLASH_DATA_W      : flash word width
//   FLASH_XFER_CYCLES : nominal engine transfer time, in cycles, for one word
package spi_flash_arb_pkg;

    localparam int unsigned FLASH_ADDR_W      = 22;
    localparam int unsigned FLASH_DATA_W      = 32;
    localparam int unsigned FLASH_XFER_CYCLES = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/spi_flash_rr_arb.sv
// Two-input round-robin arbiter, purely combinational.
//   req        : request vector, bit n = port n
//   last_grant : port that was served most recently
//   gnt        : one-hot grant (all zero when nothing requests)
module spi_flash_rr_arb
    import spi_flash_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        // On a tie, the port that was not served last wins.
        if (req == 2'b11) begin
            gnt = last_grant ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/spi_flash_arbiter.sv
// Arbitrates two word-read ports onto one SPI flash read engine.
// Sequences IDLE -> ISSUE -> WAIT -> RESP, round-robin between ports,
// aborts a transfer with an error after TIMEOUT_CYCLES in WAIT.
// Optional single-entry word cache: define SPI_FLASH_ARB_CACHE_EN.
//   clk, reset_n_i         : clock, async active-low reset
//   req*_i, addr*_i        : port read request / word address
//   data*_o, valid*_o,
//   err*_o                 : port read data, completion pulse, timeout flag
//   flash_cs_o, flash_rd_o : one-cycle request strobe to the engine
//   flash_addr_o           : address of the transaction in flight
//   flash_data_i           : word returned by the engine
//   flash_ready_i          : engine idle
//   flash_valid_i          : one-cycle data-valid from the engine
module spi_flash_arbiter
    import spi_flash_arb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 127
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic                    req0_i,
    input  logic                    req1_i,
    input  logic [FLASH_ADDR_W-1:0] addr0_i,
    input  logic [FLASH_ADDR_W-1:0] addr1_i,
    output logic [FLASH_DATA_W-1:0] data0_o,
    output logic [FLASH_DATA_W-1:0] data1_o,
    output logic                    valid0_o,
    output logic                    valid1_o,
    output logic                    err0_o,
    output logic                    err1_o,
    output logic                    flash_cs_o,
    output logic                    flash_rd_o,
    output logic [FLASH_ADDR_W-1:0] flash_addr_o,
    input  logic [FLASH_DATA_W-1:0] flash_data_i,
    input  logic                    flash_ready_i,
    input  logic                    flash_valid_i
);

    localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t              state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic                    winner_q, winner_d;
    logic [FLASH_ADDR_W-1:0] addr_q, addr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    strobe_q, strobe_d;
    logic                    valid0_q, valid0_d;
    logic                    valid1_q, valid1_d;
    logic                    err0_q, err0_d;
    logic                    err1_q, err1_d;
    logic [FLASH_DATA_W-1:0] data0_q, data0_d;
    logic [FLASH_DATA_W-1:0] data1_q, data1_d;

    logic [1:0]              req;
    logic [1:0]              gnt;
    logic [FLASH_ADDR_W-1:0] win_addr;
    logic                    cache_hit;
    logic [FLASH_DATA_W-1:0] cache_data;

    logic                    resp_go;
    logic                    resp_port;
    logic                    resp_err;
    logic [FLASH_DATA_W-1:0] resp_data;

    assign req      = {req1_i, req0_i};
    assign win_addr = gnt[1] ? addr1_i : addr0_i;

    spi_flash_rr_arb u_rr_arb (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt)
    );

`ifdef SPI_FLASH_ARB_CACHE_EN
    logic                    cvld_q, cvld_d;
    logic [FLASH_ADDR_W-1:0] ctag_q, ctag_d;
    logic [FLASH_DATA_W-1:0] cdata_q, cdata_d;

    assign cache_hit  = cvld_q && (ctag_q == win_addr);
    assign cache_data = cdata_q;

    always_comb begin
        cvld_d  = cvld_q;
        ctag_d  = ctag_q;
        cdata_d = cdata_q;
        // A completed fill is kept even if the requester has given up.
        if ((state_q == WAIT) && flash_valid_i) begin
            cvld_d  = 1'b1;
            ctag_d  = addr_q;
            cdata_d = flash_data_i;
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cvld_q  <= 1'b0;
            ctag_q  <= '0;
            cdata_q <= '0;
        end else begin
            cvld_q  <= cvld_d;
            ctag_q  <= ctag_d;
            cdata_q <= cdata_d;
        end
    end
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        winner_d     = winner_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        strobe_d     = 1'b0;
        valid0_d     = 1'b0;
        valid1_d     = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        data0_d      = data0_q;
        data1_d      = data1_q;
        resp_go      = 1'b0;
        resp_port    = winner_q;
        resp_err     = 1'b0;
        resp_data    = '0;

        unique case (state_q)
            IDLE: begin
                if (|gnt) begin
                    if (cache_hit) begin
                        winner_d  = gnt[1];
                        resp_go   = 1'b1;
                        resp_port = gnt[1];
                        resp_data = cache_data;
                    end else if (flash_ready_i) begin
                        winner_d = gnt[1];
                        addr_d   = win_addr;
                        strobe_d = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (flash_valid_i) begin
                    resp_go   = 1'b1;
                    resp_data = flash_data_i;
                end else if (cnt_q == CNT_LAST) begin
                    resp_go  = 1'b1;
                    resp_err = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                last_grant_d = winner_q;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Response outputs are registered; a port that dropped its request gets no pulse.
        if (resp_go) begin
            state_d = RESP;
            if (resp_port && req1_i) begin
                valid1_d = 1'b1;
                err1_d   = resp_err;
                data1_d  = resp_data;
            end else if (!resp_port && req0_i) begin
                valid0_d = 1'b1;
                err0_d   = resp_err;
                data0_d  = resp_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            winner_q     <= 1'b0;
            addr_q       <= '0;
            cnt_q        <= '0;
            strobe_q     <= 1'b0;
            valid0_q     <= 1'b0;
            valid1_q     <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            data0_q      <= '0;
            data1_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            winner_q     <= winner_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            strobe_q     <= strobe_d;
            valid0_q     <= valid0_d;
            valid1_q     <= valid1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            data0_q      <= data0_d;
            data1_q      <= data1_d;
        end
    end

    assign flash_cs_o   = strobe_q;
    assign flash_rd_o   = strobe_q;
    assign flash_addr_o = addr_q;
    assign valid0_o     = valid0_q;
    assign valid1_o     = valid1_q;
    assign err0_o       = err0_q;
    assign err1_o       = err1_q;
    assign data0_o      = data0_q;
    assign data1_o      = data1_q;

endmodule
